io_barrel_shifter: RTL

- Parametrised successor to the port-mapped hardware shifter used by the i8080 arcade top level.
- Keeps a history of the last DEPTH words written; returns an XLEN-bit window at a programmable bit offset.
- Supports left or right extraction and a registered read handshake.
- The shift is computed either in one cycle or iteratively, one bit per cycle, for area-constrained builds.
- Sits on the CPU I/O decode; the top level maps write-data, write-amount and read ports onto I/O addresses.

---
 rtl/io_barrel_shifter.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/io_barrel_shifter.sv
// io_barrel_shifter: history of the last DEPTH written words with an
// XLEN-bit extraction window at a programmable bit offset.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wr_data_en/wr_data  push a word (newest word lands in the MSBs)
//   wr_amt_en/wr_amt    load offset (saturating), wr_dir, wr_rev
//   flush               clear history (wins over wr_data_en)
//   rd_req/rd_ready     request handshake (ignored while not ready)
//   rd_valid/rd_data    one-cycle result pulse, data held until next
//
// Parameters: XLEN, DEPTH (>=2), ITERATIVE (0 = single cycle,
// 1 = one bit per cycle), AMT_W (derived offset width).
//
// Optional feature macro: IO_BARREL_SHIFTER_REVERSE_EN
//   defined   : rev flag register exists; rev=1 bit-reverses rd_data
//   undefined : wr_rev is ignored, rd_data never reversed
module io_barrel_shifter #(
    parameter int XLEN      = 8,
    parameter int DEPTH     = 2,
    parameter int ITERATIVE = 0,
    parameter int AMT_W     = $clog2((DEPTH-1)*XLEN+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_data_en,
    input  logic [XLEN-1:0]  wr_data,
    input  logic             wr_amt_en,
    input  logic [AMT_W-1:0] wr_amt,
    input  logic             wr_dir,
    input  logic             wr_rev,
    input  logic             flush,
    input  logic             rd_req,
    output logic             rd_ready,
    output logic             rd_valid,
    output logic [XLEN-1:0]  rd_data
);

    localparam int HW   = DEPTH * XLEN;
    localparam int MAXA = (DEPTH - 1) * XLEN;

    localparam logic [AMT_W-1:0] MAX_AMT = AMT_W'(MAXA);

    logic [HW-1:0]    r_hist;
    logic [AMT_W-1:0] r_amt;
    logic             r_dir;
    logic             w_rev;
    logic [XLEN-1:0]  r_rd_data;
    logic             r_rd_valid;

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

    // Select the output window from an already-shifted history and
    // optionally bit-reverse it.
    function automatic logic [XLEN-1:0] f_final(
        input logic [HW-1:0] s,
        input logic          dir,
        input logic          rev
    );
        logic [XLEN-1:0] w_win;
        logic [XLEN-1:0] w_flip;
        w_win = dir ? s[XLEN-1:0] : s[HW-1 -: XLEN];
        for (int i = 0; i < XLEN; i++) begin
            w_flip[i] = w_win[XLEN-1-i];
        end
        return rev ? w_flip : w_win;
    endfunction

    // History: newest word enters at the top, oldest drops off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
        end else if (flush) begin
            r_hist <= '0;
        end else if (wr_data_en) begin
            r_hist <= {wr_data, r_hist[HW-1:XLEN]};
        end
    end

    // Offset saturates so the window never leaves the history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_amt <= '0;
            r_dir <= 1'b0;
        end else if (wr_amt_en) begin
            r_amt <= (wr_amt > MAX_AMT) ? MAX_AMT : wr_amt;
            r_dir <= wr_dir;
        end
    end

`ifdef IO_BARREL_SHIFTER_REVERSE_EN
    logic r_rev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rev <= 1'b0;
        end else if (wr_amt_en) begin
            r_rev <= wr_rev;
        end
    end

    assign w_rev = r_rev;
`else
    logic w_unused_rev;

    assign w_unused_rev = wr_rev;
    assign w_rev        = 1'b0;
`endif

    if (ITERATIVE == 0) begin : g_comb

        logic [HW-1:0] w_shl;
        logic [HW-1:0] w_shr;
        logic [HW-1:0] w_src;

        assign w_shl = r_hist << r_amt;
        assign w_shr = r_hist >> r_amt;
        assign w_src = r_dir ? w_shr : w_shl;

        assign rd_ready = 1'b1;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= rd_req;
                if (rd_req) begin
                    r_rd_data <= f_final(w_src, r_dir, w_rev);
                end
            end
        end

    end else begin : g_iter

        typedef enum logic [1:0] {
            S_IDLE,
            S_SHIFT,
            S_DONE
        } state_t;

        state_t           r_state;
        state_t           w_state_nxt;
        logic [HW-1:0]    r_work;
        logic [HW-1:0]    w_work_nxt;
        logic [HW-1:0]    w_step;
        logic [AMT_W-1:0] r_cnt;
        logic [AMT_W-1:0] w_cnt_nxt;
        logic             r_sdir;
        logic             r_srev;
        logic             w_fire;
        logic [HW-1:0]    w_res_src;
        logic             w_res_dir;
        logic             w_res_rev;

        assign w_step   = r_sdir ? (r_work >> 1) : (r_work << 1);
        assign rd_ready = (r_state == S_IDLE);

        always_comb begin
            w_state_nxt = r_state;
            w_work_nxt  = r_work;
            w_cnt_nxt   = r_cnt;
            w_fire      = 1'b0;
            w_res_src   = w_step;
            w_res_dir   = r_sdir;
            w_res_rev   = r_srev;
            unique case (r_state)
                S_IDLE: begin
                    if (rd_req) begin
                        if (r_amt == '0) begin
                            // Zero offset skips SHIFT entirely.
                            w_state_nxt = S_DONE;
                            w_fire      = 1'b1;
                            w_res_src   = r_hist;
                            w_res_dir   = r_dir;
                            w_res_rev   = w_rev;
                        end else begin
                            w_state_nxt = S_SHIFT;
                            w_work_nxt  = r_hist;
                            w_cnt_nxt   = r_amt;
                        end
                    end
                end
                S_SHIFT: begin
                    w_work_nxt = w_step;
                    w_cnt_nxt  = r_cnt - 1'b1;
                    // Result is captured on the last shift so that
                    // rd_valid lines up with the DONE cycle.
                    if (r_cnt == AMT_W'(1)) begin
                        w_state_nxt = S_DONE;
                        w_fire      = 1'b1;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= S_IDLE;
                r_work  <= '0;
                r_cnt   <= '0;
                r_sdir  <= 1'b0;
                r_srev  <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_work  <= w_work_nxt;
                r_cnt   <= w_cnt_nxt;
                // Snapshot so register writes mid-shift do not leak in.
                if (r_state == S_IDLE && rd_req) begin
                    r_sdir <= r_dir;
                    r_srev <= w_rev;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rd_data  <= '0;
                r_rd_valid <= 1'b0;
            end else begin
                r_rd_valid <= w_fire;
                if (w_fire) begin
                    r_rd_data <= f_final(w_res_src, w_res_dir, w_res_rev);
                end
            end
        end

    end

endmodule
